// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU control decoder between decode and execute.
// M-extension ops are held in the stage while the iterative MUL/DIV unit runs.
module alu_ctrl_pipe #(
  parameter int MULDIV_EN = 1,
  parameter int MD_CYCLES = 32,
  localparam int CNT_W = $clog2(MD_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] alu_ctrl,
  output logic       illegal,
  output logic       md_start,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. Producers may not drop valid or change data while ready is low;
  // ready never depends on the same-side valid.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MD_RUN = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  state_t            state, state_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              out_valid_n;
  logic [5:0]        alu_ctrl_n;
  logic              illegal_n;
  logic              md_start_n;
  logic [2:0]        pend_f3, pend_f3_n;

  logic [5:0]        dec_ctrl;
  logic              dec_illegal;
  logic              dec_md;
  logic              accept;

  // Control word layout: {muldiv, func3[2:0], alt, imm_b}.
  always_comb begin
    dec_ctrl    = '0;
    dec_illegal = 1'b0;
    dec_md      = 1'b0;
    case (opcode)
      OP_R: begin
        case (func7)
          F7_BASE: dec_ctrl = {1'b0, func3, 2'b00};
          F7_ALT: begin
            if (func3 == 3'b000 || func3 == 3'b101) begin
              dec_ctrl = {1'b0, func3, 2'b10};
            end else begin
              dec_illegal = 1'b1;
            end
          end
          F7_MD: begin
            if (MULDIV_EN != 0) begin
              dec_ctrl = {1'b1, func3, 2'b00};
              dec_md   = 1'b1;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        // func7 only carries meaning for the shift-immediate forms.
        if (func3 == 3'b001 && func7 != F7_BASE) begin
          dec_illegal = 1'b1;
        end else if (func3 == 3'b101 && func7 != F7_BASE && func7 != F7_ALT) begin
          dec_illegal = 1'b1;
        end else begin
          dec_ctrl = {1'b0, func3, (func3 == 3'b101) ? func7[5] : 1'b0, 1'b1};
        end
      end
      OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: dec_ctrl = 6'b000001;
      OP_BRANCH: dec_ctrl = 6'b000010;
      default:   dec_illegal = 1'b1;
    endcase
  end

  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state == MD_RUN);
  assign dbg_state = state;

  always_comb begin
    state_n     = state;
    count_n     = count;
    out_valid_n = out_valid;
    alu_ctrl_n  = alu_ctrl;
    illegal_n   = illegal;
    md_start_n  = 1'b0;
    pend_f3_n   = pend_f3;
    case (state)
      IDLE: begin
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
        end
        if (accept) begin
          if (dec_md) begin
            // Visible outputs keep the previous word until the M-op result lands.
            state_n     = MD_RUN;
            md_start_n  = 1'b1;
            count_n     = CNT_W'(MD_CYCLES);
            out_valid_n = 1'b0;
            pend_f3_n   = func3;
          end else begin
            out_valid_n = 1'b1;
            alu_ctrl_n  = dec_ctrl;
            illegal_n   = dec_illegal;
          end
        end
      end
      MD_RUN: begin
        if (count == CNT_W'(1)) begin
          state_n     = DONE;
          count_n     = '0;
          out_valid_n = 1'b1;
          alu_ctrl_n  = {1'b1, pend_f3, 2'b00};
          illegal_n   = 1'b0;
        end else begin
          count_n = count - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n     = IDLE;
          out_valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      out_valid <= 1'b0;
      alu_ctrl  <= '0;
      illegal   <= 1'b0;
      md_start  <= 1'b0;
      pend_f3   <= '0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      out_valid <= out_valid_n;
      alu_ctrl  <= alu_ctrl_n;
      illegal   <= illegal_n;
      md_start  <= md_start_n;
      pend_f3   <= pend_f3_n;
    end
  end

endmodule
